// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port byte-addressed memory between the
// CPU fetch port (read-only) and the data port (read/write with byte enables).
// One transaction at a time. Data wins ties unless fetch has been passed over
// STARVE_LIMIT times in a row.
//
// Ports:
//   clk, reset_n             clock, async active-low reset
//   i_req/i_addr             fetch request and byte address
//   i_gnt/i_rvalid/i_rdata   fetch grant pulse, read-valid pulse, fetched word
//   d_req/d_we/d_addr/d_be/d_wdata  data request fields
//   d_gnt/d_rvalid/d_rdata   data grant pulse, read-valid pulse, read word
//   mem_*                    memory command bus (registered); mem_data_out is
//                            the registered memory read data
//   busy                     high whenever the arbiter is not in IDLE
module mips_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_wr_en,
  output logic        mem_read_en,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q, state_nxt;
  logic                  owner_d_q, owner_d_nxt;   // 1 = data port owns the bus
  logic                  is_wr_q, is_wr_nxt;
  logic [STREAK_W-1:0]   streak_q, streak_nxt;
  logic [31:0]           i_rdata_q, i_rdata_nxt;
  logic [31:0]           d_rdata_q, d_rdata_nxt;

  logic [31:0]           mem_address_nxt, mem_data_in_nxt;
  logic                  mem_wr_en_nxt, mem_read_en_nxt;
  logic [3:0]            mem_byte_en_nxt;
  logic                  i_gnt_nxt, d_gnt_nxt, i_rvalid_nxt, d_rvalid_nxt;
  logic                  busy_nxt;

  logic                  starved;
  logic                  fetch_wins;

  assign starved    = (streak_q == STREAK_W'(STARVE_LIMIT));
  assign fetch_wins = i_req && (!d_req || starved);

  // State and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      is_wr_q     <= 1'b0;
      streak_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_address <= '0;
      mem_wr_en   <= 1'b0;
      mem_read_en <= 1'b0;
      mem_byte_en <= '0;
      mem_data_in <= '0;
      i_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      i_rvalid    <= 1'b0;
      d_rvalid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      owner_d_q   <= owner_d_nxt;
      is_wr_q     <= is_wr_nxt;
      streak_q    <= streak_nxt;
      i_rdata_q   <= i_rdata_nxt;
      d_rdata_q   <= d_rdata_nxt;
      mem_address <= mem_address_nxt;
      mem_wr_en   <= mem_wr_en_nxt;
      mem_read_en <= mem_read_en_nxt;
      mem_byte_en <= mem_byte_en_nxt;
      mem_data_in <= mem_data_in_nxt;
      i_gnt       <= i_gnt_nxt;
      d_gnt       <= d_gnt_nxt;
      i_rvalid    <= i_rvalid_nxt;
      d_rvalid    <= d_rvalid_nxt;
      busy        <= busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (i_req || d_req) state_nxt = CMD;
      CMD:     state_nxt = is_wr_q ? IDLE : RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    owner_d_nxt     = owner_d_q;
    is_wr_nxt       = is_wr_q;
    streak_nxt      = streak_q;
    i_rdata_nxt     = i_rdata_q;
    d_rdata_nxt     = d_rdata_q;
    mem_address_nxt = mem_address;
    mem_data_in_nxt = mem_data_in;
    mem_byte_en_nxt = mem_byte_en;
    mem_wr_en_nxt   = 1'b0;
    mem_read_en_nxt = 1'b0;
    i_gnt_nxt       = 1'b0;
    d_gnt_nxt       = 1'b0;
    i_rvalid_nxt    = 1'b0;
    d_rvalid_nxt    = 1'b0;
    busy_nxt        = (state_nxt != IDLE);

    unique case (state_q)
      IDLE: begin
        if (!i_req) streak_nxt = '0;
        if (fetch_wins) begin
          owner_d_nxt     = 1'b0;
          is_wr_nxt       = 1'b0;
          streak_nxt      = '0;
          mem_address_nxt = i_addr;
          mem_read_en_nxt = 1'b1;
          mem_byte_en_nxt = 4'b1111;
          mem_data_in_nxt = '0;
          i_gnt_nxt       = 1'b1;
        end else if (d_req) begin
          owner_d_nxt     = 1'b1;
          is_wr_nxt       = d_we;
          mem_address_nxt = d_addr;
          mem_wr_en_nxt   = d_we;
          mem_read_en_nxt = !d_we;
          mem_byte_en_nxt = d_be;
          mem_data_in_nxt = d_we ? d_wdata : 32'h0;
          d_gnt_nxt       = 1'b1;
          // Count data wins only while fetch is actually waiting
          if (i_req && !starved) streak_nxt = streak_q + STREAK_W'(1);
        end
      end
      CMD: begin
        if (!is_wr_q) begin
          i_rvalid_nxt = !owner_d_q;
          d_rvalid_nxt = owner_d_q;
        end
      end
      RESP: begin
        // Latch the word so each port's rdata holds once RESP is over
        if (owner_d_q) d_rdata_nxt = mem_data_out;
        else           i_rdata_nxt = mem_data_out;
      end
      default: ;
    endcase
  end

  // Owner sees memory data directly during RESP; otherwise last captured word
  assign i_rdata = (state_q == RESP && !owner_d_q) ? mem_data_out : i_rdata_q;
  assign d_rdata = (state_q == RESP &&  owner_d_q) ? mem_data_out : d_rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a byte-addressed big-endian memory model.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_address, mem_data_in;
  logic        mem_wr_en, mem_read_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_data_out = '0;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  mips_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en),
    .mem_byte_en(mem_byte_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: be[3] is the byte at the address (bits 31:24), registered read
  logic [31:0] mem [logic [29:0]];
  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_wr_en) begin
      w = mem.exists(mem_address[31:2]) ? mem[mem_address[31:2]] : 32'h0;
      if (mem_byte_en[3]) w[31:24] = mem_data_in[31:24];
      if (mem_byte_en[2]) w[23:16] = mem_data_in[23:16];
      if (mem_byte_en[1]) w[15:8]  = mem_data_in[15:8];
      if (mem_byte_en[0]) w[7:0]   = mem_data_in[7:0];
      mem[mem_address[31:2]] = w;
    end
    if (mem_read_en)
      mem_data_out <= mem.exists(mem_address[31:2]) ? mem[mem_address[31:2]] : 32'h0;
  end

  // Drive one data request from a negedge; returns after the arbiter is idle again
  task automatic do_data(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] rd, output logic ok);
    ok = 1'b0;
    rd = '0;
    d_req = 1'b1; d_we = we; d_addr = a; d_be = be; d_wdata = wd;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (d_gnt) ok = 1'b1;
    end
    d_req = 1'b0;
    if (ok && !we) begin
      ok = 1'b0;
      for (int n = 0; n < 5 && !ok; n++) begin
        @(negedge clk);
        if (d_rvalid) begin ok = 1'b1; rd = d_rdata; end
      end
    end
    for (int n = 0; n < 5 && busy; n++) @(negedge clk);
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    @(negedge clk); @(negedge clk);
    n_total++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, busy} !== 5'b0) $display("FAIL reset_ctl: got %b want 00000", {i_gnt, d_gnt, i_rvalid, d_rvalid, busy});
    else n_pass++;
    n_total++;
    if ({mem_wr_en, mem_read_en, mem_byte_en} !== 6'b0) $display("FAIL reset_mem_en: got %b want 000000", {mem_wr_en, mem_read_en, mem_byte_en});
    else n_pass++;
    n_total++;
    if (mem_address !== 32'h0 || mem_data_in !== 32'h0) $display("FAIL reset_mem_bus: addr %h data %h want 0", mem_address, mem_data_in);
    else n_pass++;
    n_total++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) $display("FAIL reset_rdata: i %h d %h want 0", i_rdata, d_rdata);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Cycle-exact fetch of 0xBFC00000 expecting 0x3C011234
  task automatic check_fetch(input string tag);
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    @(negedge clk);
    n_total++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || busy !== 1'b1) $display("FAIL %s_c1_gnt: i_gnt %b d_gnt %b busy %b want 1 0 1", tag, i_gnt, d_gnt, busy);
    else n_pass++;
    n_total++;
    if (mem_read_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_byte_en !== 4'hF || mem_address !== 32'hBFC0_0000)
      $display("FAIL %s_c1_cmd: rd %b wr %b be %h addr %h want 1 0 f bfc00000", tag, mem_read_en, mem_wr_en, mem_byte_en, mem_address);
    else n_pass++;
    i_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (i_rvalid !== 1'b1 || i_gnt !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s_c2_rvalid: i_rvalid %b i_gnt %b d_rvalid %b busy %b want 1 0 0 1", tag, i_rvalid, i_gnt, d_rvalid, busy);
    else n_pass++;
    n_total++;
    if (i_rdata !== 32'h3C01_1234) $display("FAIL %s_c2_rdata: got %h want 3c011234", tag, i_rdata);
    else n_pass++;
    n_total++;
    if (mem_read_en !== 1'b0) $display("FAIL %s_c2_rden: got %b want 0", tag, mem_read_en);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || i_rvalid !== 1'b0 || i_rdata !== 32'h3C01_1234)
      $display("FAIL %s_c3_idle: busy %b i_rvalid %b i_rdata %h want 0 0 3c011234", tag, busy, i_rvalid, i_rdata);
    else n_pass++;
  endtask

  task automatic test_fetch_alone;
    logic [31:0] rd;
    logic ok;
    do_data(1'b1, 32'hBFC0_0000, 4'hF, 32'h3C01_1234, rd, ok);
    n_total++;
    if (!ok) $display("FAIL preload_write: got no d_gnt want d_gnt");
    else n_pass++;
    check_fetch("fetch");
  endtask

  task automatic test_data_wr_rd;
    logic [31:0] rd;
    logic ok;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_be = 4'hF; d_wdata = 32'h0000_004F;
    @(negedge clk);
    n_total++;
    if (d_gnt !== 1'b1 || mem_wr_en !== 1'b1 || mem_read_en !== 1'b0 || mem_data_in !== 32'h4F || mem_address !== 32'h8)
      $display("FAIL wr_cmd: gnt %b wr %b rd %b data %h addr %h want 1 1 0 4f 8", d_gnt, mem_wr_en, mem_read_en, mem_data_in, mem_address);
    else n_pass++;
    d_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || d_rvalid !== 1'b0 || mem_wr_en !== 1'b0) $display("FAIL wr_done: busy %b rvalid %b wr %b want 0 0 0", busy, d_rvalid, mem_wr_en);
    else n_pass++;
    do_data(1'b0, 32'h8, 4'hF, 32'h0, rd, ok);
    n_total++;
    if (!ok || rd !== 32'h0000_004F) $display("FAIL rd_back: ok %b got %h want 0000004f", ok, rd);
    else n_pass++;
  endtask

  task automatic test_partial;
    logic [31:0] rd;
    logic ok;
    do_data(1'b1, 32'h8, 4'hF, 32'hAABB_CCDD, rd, ok);
    do_data(1'b1, 32'h8, 4'b0101, 32'h1122_3344, rd, ok);
    do_data(1'b0, 32'h8, 4'hF, 32'h0, rd, ok);
    n_total++;
    if (!ok || rd !== 32'hAA22_CC44) $display("FAIL partial_be0101: ok %b got %h want aa22cc44", ok, rd);
    else n_pass++;
    // Zero byte enables: still a granted write, but nothing changes
    do_data(1'b1, 32'h8, 4'b0000, 32'hFFFF_FFFF, rd, ok);
    n_total++;
    if (!ok) $display("FAIL be0_gnt: got no d_gnt want d_gnt");
    else n_pass++;
    do_data(1'b0, 32'h8, 4'hF, 32'h0, rd, ok);
    n_total++;
    if (!ok || rd !== 32'hAA22_CC44) $display("FAIL be0_unchanged: ok %b got %h want aa22cc44", ok, rd);
    else n_pass++;
  endtask

  task automatic test_contention;
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_be = 4'hF;
    @(negedge clk);
    n_total++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0) $display("FAIL cont_first: d_gnt %b i_gnt %b want 1 0", d_gnt, i_gnt);
    else n_pass++;
    d_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rdata !== 32'hAA22_CC44)
      $display("FAIL cont_drd: d_rvalid %b i_rvalid %b d_rdata %h want 1 0 aa22cc44", d_rvalid, i_rvalid, d_rdata);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (i_gnt !== 1'b0 || busy !== 1'b0) $display("FAIL cont_gap: i_gnt %b busy %b want 0 0", i_gnt, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL cont_second: i_gnt %b d_gnt %b want 1 0", i_gnt, d_gnt);
    else n_pass++;
    i_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'h3C01_1234) $display("FAIL cont_ird: i_rvalid %b i_rdata %h want 1 3c011234", i_rvalid, i_rdata);
    else n_pass++;
    n_total++;
    if (d_rdata !== 32'hAA22_CC44) $display("FAIL cont_dhold: d_rdata %h want aa22cc44", d_rdata);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_starvation;
    string       want = "DDDDIDD";
    logic [7:0]  seq [7];
    int          ng = 0;
    logic        overlap = 1'b0;
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_be = 4'hF;
    for (int n = 0; n < 80 && ng < 7; n++) begin
      @(negedge clk);
      if ((i_gnt && d_gnt) || (i_rvalid && d_rvalid) || (mem_wr_en && mem_read_en)) overlap = 1'b1;
      if (d_gnt)      begin seq[ng] = "D"; ng++; end
      else if (i_gnt) begin seq[ng] = "I"; ng++; end
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int n = 0; n < 5 && busy; n++) @(negedge clk);
    n_total++;
    if (ng !== 7) $display("FAIL starve_count: got %0d grants want 7", ng);
    else n_pass++;
    for (int k = 0; k < 7; k++) begin
      n_total++;
      if (k >= ng || seq[k] !== want[k]) $display("FAIL starve_order[%0d]: got %s want %s", k, (k < ng) ? string'(seq[k]) : "none", string'(want[k]));
      else n_pass++;
    end
    n_total++;
    if (overlap) $display("FAIL starve_overlap: got overlap want none");
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic saw_rvalid = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_be = 4'hF;
    @(posedge clk); #1;
    n_total++;
    if (mem_read_en !== 1'b1 || d_gnt !== 1'b1) $display("FAIL rmid_cmd: rd %b d_gnt %b want 1 1", mem_read_en, d_gnt);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if (mem_read_en !== 1'b0 || mem_wr_en !== 1'b0 || d_gnt !== 1'b0 || busy !== 1'b0)
      $display("FAIL rmid_drop: rd %b wr %b d_gnt %b busy %b want 0 0 0 0", mem_read_en, mem_wr_en, d_gnt, busy);
    else n_pass++;
    d_req = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (d_rvalid) saw_rvalid = 1'b1;
    end
    reset_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (d_rvalid) saw_rvalid = 1'b1;
    end
    n_total++;
    if (saw_rvalid) $display("FAIL rmid_no_rvalid: got d_rvalid want none");
    else n_pass++;
    check_fetch("rmid_fetch");
  endtask

  initial begin
    test_reset();
    test_fetch_alone();
    test_data_wr_rd();
    test_partial();
    test_contention();
    test_starvation();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
